cby_param_ccff: RTL and testbench
=================================

# cby_param_ccff

Parametrised Y-direction connection block for the FPGA fabric. It passes vertical routing tracks straight through between its bottom and top neighbours. It also drives NUM_IPIN grid input pins, each through a MUX_SIZE-input routing multiplexer. Configuration arrives over a serial configuration-chain flip-flop (CCFF) path with double buffering, so the fabric only sees new multiplexer selects after a complete, verified frame is committed.

## Interface
Parameters:
- CHAN_W, 13: tracks per direction.
- NUM_IPIN, 11: grid input pins driven. Pin k < NUM_IPIN/2 rounded up goes to the right grid; the rest go to the left grid.
- MUX_SIZE, 6: inputs per pin mux. Must be even and ≥ 2.
- SEL_W, 3: select bits per mux. Must satisfy 2^SEL_W > MUX_SIZE.
- Derived:
  - TOTAL = NUM_IPIN*SEL_W (default 33).
  - STRIDE = CHAN_W / (MUX_SIZE/2), integer division (default 4).
  - CW = bits needed to hold TOTAL+1.

Ports:
- prog_clk, input, 1: configuration clock, the only clock.
- pReset, input, 1: asynchronous, active-high reset.
- chany_bottom_in, input, CHAN_W: tracks entering from below.
- chany_top_in, input, CHAN_W: tracks entering from above.
- chany_bottom_out, output, CHAN_W: equals chany_top_in, combinational.
- chany_top_out, output, CHAN_W: equals chany_bottom_in, combinational.
- config_enable, input, 1: shift one chain bit on this edge.
- ccff_head, input, 1: serial configuration data in.
- ccff_tail, output, 1: serial data out; equals shift_reg[TOTAL-1].
- cfg_commit, input, 1: single-cycle request to copy the shift register into the active selects.
- cfg_loaded, output, 1: sticky; at least one commit has succeeded since reset.
- cfg_error, output, 1: sticky; a commit was attempted with a bit count ≠ TOTAL.
- ipin_out, output, NUM_IPIN: grid input pin drives.

## Operation
Storage:
- shift_reg[TOTAL-1:0], active_sel[TOTAL-1:0], bit_cnt[CW-1:0], and the two sticky flags.

Shift (config_enable=1, cfg_commit=0):
- shift_reg[0] ← ccff_head.
- shift_reg[i] ← shift_reg[i-1].
- bit_cnt increments and saturates at TOTAL+1.

Commit (cfg_commit=1):
- If bit_cnt == TOTAL: active_sel ← shift_reg, cfg_loaded ← 1.
- Otherwise: active_sel is unchanged and cfg_error ← 1.
- In both cases bit_cnt ← 0.
- Commit has priority. If config_enable is also high that cycle, the shift is dropped and the bit is lost.

Idle: when neither input is asserted, all state holds.

Mux mapping for pin k:
- sel_k = active_sel[k*SEL_W +: SEL_W].
- Tap j (0..MUX_SIZE/2-1) uses track t_j = (k + j*STRIDE) mod CHAN_W.
- Mux inputs, in order: {bottom[t_0], top[t_0], bottom[t_1], top[t_1], …}.
- sel_k = 0 means disconnected: ipin_out[k] = 0.
- sel_k = v with 1 ≤ v ≤ MUX_SIZE: ipin_out[k] = input[v-1].
- sel_k > MUX_SIZE: ipin_out[k] = 0.

Chain ordering:
- The first bit shifted in after a commit or reset lands in the MSB of pin NUM_IPIN-1.
- The last bit shifted lands in the LSB of pin 0.

## Timing
Reset (pReset high, takes effect immediately, no clock needed):
- shift_reg = 0, active_sel = 0, bit_cnt = 0.
- cfg_loaded = 0, cfg_error = 0, ccff_tail = 0.
- All ipin_out = 0, because every select is 0.
- Pass-through tracks stay live during reset.
- Reset asserted mid-shift discards the partial frame. Reset during a commit edge: reset wins.

Latencies:
- ccff_tail is registered. A bit at ccff_head appears on ccff_tail TOTAL edges later.
- A new select is visible on ipin_out combinationally after the commit edge, i.e. in the cycle following the one where cfg_commit is sampled high.
- Track-to-ipin and track-to-track paths are purely combinational, 0 cycles.

Boundaries:
- Shifting past TOTAL bits: bit_cnt holds at TOTAL+1, so the next commit fails. The shift register still holds the most recent TOTAL bits.
- Commit with bit_cnt = 0: fails and sets cfg_error. Active selects are kept.
- Back-to-back commits: the second one sees bit_cnt = 0 and fails.
- The sticky flags clear only on pReset.
- Shifting never disturbs ipin_out before a commit (glitch-free double buffer).

## Test plan
- Reset: assert pReset with tracks toggling → ipin_out = 0, cfg_loaded = 0, cfg_error = 0, ccff_tail = 0; chany_top_out tracks chany_bottom_in.
- Full frame, defaults:
  - Stimulus: shift 33 bits, then commit, selecting pin 0 = 4 and pin 10 = 6; all other pins 0.
  - Pin 0 follows chany_top_in[4].
  - Pin 10 follows chany_top_in[5], since its taps are tracks 10, 1, 5.
  - All other pins are 0; cfg_loaded = 1.
- Short frame: shift 32 bits, then commit → cfg_error = 1, previous ipin_out mapping unchanged; a subsequent correct 33-bit frame and commit then succeeds with cfg_error still 1.
- Overshift plus collision: shift 34 bits, then commit → fails. Next, shift 33 bits and raise cfg_commit together with config_enable on the 33rd → commit sees 32 bits and fails; the 33rd bit is not stored.
- Chain loop-through: shift a 66-bit pattern → bits 1–33 reappear on ccff_tail exactly 33 edges after entry; ipin_out is unchanged throughout.
- Out-of-range select and mid-shift reset:
  - Commit pin 3 = 7 → ipin_out[3] = 0.
  - Pulse pReset after 10 shift bits → all state returns to reset values.

Source files
------------

// File: rtl/cby_param_ccff_if.sv
`default_nettype none
// ============================================================================
// Module   : cby_param_ccff_if
// Purpose  : Signal bundle for the Y-direction connection block. It carries
//            the routing tracks, the serial configuration chain controls and
//            the grid input pin drives.
// Revision : 1.0 - initial release
// ============================================================================
interface cby_param_ccff_if #(
   parameter int CHAN_W   = 13,
   parameter int NUM_IPIN = 11
);
   logic [CHAN_W-1:0]   chany_bottom_in;
   logic [CHAN_W-1:0]   chany_top_in;
   logic [CHAN_W-1:0]   chany_bottom_out;
   logic [CHAN_W-1:0]   chany_top_out;
   logic                config_enable;
   logic                ccff_head;
   logic                ccff_tail;
   logic                cfg_commit;
   logic                cfg_loaded;
   logic                cfg_error;
   logic [NUM_IPIN-1:0] ipin_out;

   // Fabric / configuration controller side
   modport master (
      output chany_bottom_in, chany_top_in, config_enable, ccff_head, cfg_commit,
      input  chany_bottom_out, chany_top_out, ccff_tail, cfg_loaded, cfg_error, ipin_out
   );

   // Connection block side
   modport slave (
      input  chany_bottom_in, chany_top_in, config_enable, ccff_head, cfg_commit,
      output chany_bottom_out, chany_top_out, ccff_tail, cfg_loaded, cfg_error, ipin_out
   );
endinterface
`default_nettype wire

// File: rtl/cby_param_ccff.sv
`default_nettype none
// ============================================================================
// Module   : cby_param_ccff
// Purpose  : Parametrised Y-direction connection block. Vertical tracks pass
//            straight through; each grid input pin is driven by a MUX_SIZE
//            input routing mux whose select is loaded over a double-buffered
//            serial configuration chain. Pins below ceil(NUM_IPIN/2) feed
//            the right grid, the remainder feed the left grid.
// Revision : 1.0 - initial release
// ============================================================================
module cby_param_ccff #(
   parameter int CHAN_W   = 13,
   parameter int NUM_IPIN = 11,
   parameter int MUX_SIZE = 6,
   parameter int SEL_W    = 3
) (
   input  logic             prog_clk,
   input  logic             pReset,
   cby_param_ccff_if.slave  bus
);

   localparam int TOTAL  = NUM_IPIN * SEL_W;
   localparam int HALF   = MUX_SIZE / 2;
   localparam int STRIDE = CHAN_W / HALF;
   localparam int CW     = $clog2(TOTAL + 2);

   // Reject geometries where a select cannot address every mux input
   if ((MUX_SIZE % 2) != 0 || MUX_SIZE < 2 || (1 << SEL_W) <= MUX_SIZE) begin : g_param_check
      $error("cby_param_ccff: MUX_SIZE must be even, >= 2 and below 2**SEL_W");
   end

   logic [TOTAL-1:0]    r_shift_reg;
   logic [TOTAL-1:0]    r_active_sel;
   logic [CW-1:0]       r_bit_cnt;
   logic                r_cfg_loaded;
   logic                r_cfg_error;
   logic                w_frame_ok;
   logic [NUM_IPIN-1:0] w_ipin;

   // A commit only succeeds when exactly one full frame has been shifted in
   assign w_frame_ok = (r_bit_cnt == CW'(TOTAL));

   // Shadow chain: shifts on config_enable unless a commit claims the cycle
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_shift_reg <= '0;
      end else if (!bus.cfg_commit && bus.config_enable) begin
         r_shift_reg <= {r_shift_reg[TOTAL-2:0], bus.ccff_head};
      end
   end

   // Frame length counter: saturates one past TOTAL so overshift is remembered
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_bit_cnt <= '0;
      end else if (bus.cfg_commit) begin
         r_bit_cnt <= '0;
      end else if (bus.config_enable && (r_bit_cnt != CW'(TOTAL + 1))) begin
         r_bit_cnt <= r_bit_cnt + CW'(1);
      end
   end

   // Active selects and sticky status flags update only on a commit request
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         r_active_sel <= '0;
         r_cfg_loaded <= 1'b0;
         r_cfg_error  <= 1'b0;
      end else if (bus.cfg_commit) begin
         if (w_frame_ok) begin
            r_active_sel <= r_shift_reg;
            r_cfg_loaded <= 1'b1;
         end else begin
            r_cfg_error  <= 1'b1;
         end
      end
   end

   // Per-pin routing mux; tap j reaches track (k + j*STRIDE) mod CHAN_W,
   // offering the bottom then the top copy of that track
   for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
      logic [MUX_SIZE-1:0] w_mux_in;
      logic [SEL_W-1:0]    w_sel;
      logic                w_pin;

      assign w_sel = r_active_sel[k*SEL_W +: SEL_W];

      for (genvar j = 0; j < HALF; j++) begin : g_tap
         localparam int TRACK = (k + j * STRIDE) % CHAN_W;
         assign w_mux_in[2*j]   = bus.chany_bottom_in[TRACK];
         assign w_mux_in[2*j+1] = bus.chany_top_in[TRACK];
      end

      // Select 0 and out-of-range selects leave the pin disconnected (0)
      always_comb begin
         w_pin = 1'b0;
         for (int v = 1; v <= MUX_SIZE; v++) begin
            if (w_sel == SEL_W'(v)) begin
               w_pin = w_mux_in[v-1];
            end
         end
      end

      assign w_ipin[k] = w_pin;
   end

   assign bus.ipin_out         = w_ipin;
   assign bus.chany_bottom_out = bus.chany_top_in;
   assign bus.chany_top_out    = bus.chany_bottom_in;
   assign bus.ccff_tail        = r_shift_reg[TOTAL-1];
   assign bus.cfg_loaded       = r_cfg_loaded;
   assign bus.cfg_error        = r_cfg_error;

endmodule
`default_nettype wire

// File: tb/tb_cby_param_ccff.sv
`default_nettype none
// ============================================================================
// Module   : tb_cby_param_ccff
// Purpose  : Self-checking bench for cby_param_ccff (default geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cby_param_ccff;

   localparam int CHAN_W   = 13;
   localparam int NUM_IPIN = 11;
   localparam int MUX_SIZE = 6;
   localparam int SEL_W    = 3;
   localparam int TOTAL    = 33;

   typedef struct {
      logic [CHAN_W-1:0]   bot;
      logic [CHAN_W-1:0]   top;
      logic [NUM_IPIN-1:0] exp;
   } vec_t;

   logic prog_clk = 1'b0;
   logic pReset;

   cby_param_ccff_if #(.CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN)) bus ();

   cby_param_ccff #(
      .CHAN_W   (CHAN_W),
      .NUM_IPIN (NUM_IPIN),
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
   ) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .bus      (bus)
   );

   always #5 prog_clk = ~prog_clk;

   int checks   = 0;
   int failures = 0;
   logic [TOTAL-1:0] model_sr;

   // pin0 = 4 (top[4]), pin10 = 6 (top[5])
   localparam logic [TOTAL-1:0] CFG_A = 33'h1_8000_0004;
   // pin1 = 1 (bottom[1])
   localparam logic [TOTAL-1:0] CFG_B = 33'h0_0000_0008;
   // pin2 = 2 (top[2]), pin3 = 7 (out of range)
   localparam logic [TOTAL-1:0] CFG_C = 33'h0_0000_0E80;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference mux: tap j of pin k sits on track (k + 4j) mod 13
   function automatic logic [NUM_IPIN-1:0] ref_ipin(input logic [TOTAL-1:0] cfg,
                                                   input logic [CHAN_W-1:0] b,
                                                   input logic [CHAN_W-1:0] t);
      logic [NUM_IPIN-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_IPIN; k++) begin
         int v;
         int trk;
         v = int'(cfg[k*SEL_W +: SEL_W]);
         if (v >= 1 && v <= MUX_SIZE) begin
            trk  = (k + ((v - 1) / 2) * 4) % CHAN_W;
            r[k] = (((v - 1) % 2) == 1) ? t[trk] : b[trk];
         end
      end
      return r;
   endfunction

   task automatic set_tracks(input logic [CHAN_W-1:0] b, input logic [CHAN_W-1:0] t);
      bus.chany_bottom_in = b;
      bus.chany_top_in    = t;
      #1;
   endtask

   task automatic shift_bit(input logic b);
      bus.config_enable = 1'b1;
      bus.ccff_head     = b;
      @(posedge prog_clk);
      #1;
      bus.config_enable = 1'b0;
      model_sr = {model_sr[TOTAL-2:0], b};
   endtask

   // Shifts the low n bits of f, most significant first
   task automatic shift_frame(input logic [TOTAL-1:0] f, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(f[i]);
   endtask

   task automatic commit();
      bus.cfg_commit = 1'b1;
      @(posedge prog_clk);
      #1;
      bus.cfg_commit = 1'b0;
   endtask

   vec_t tab [8];
   logic [65:0] pat;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{13'h1FFF, 13'h0000, 11'h000};
      tab[1] = '{13'h0000, 13'h0010, 11'h001};
      tab[2] = '{13'h0000, 13'h0020, 11'h400};
      tab[3] = '{13'h0000, 13'h0030, 11'h401};
      tab[4] = '{13'h1FFF, 13'h1FCF, 11'h000};
      tab[5] = '{13'h0000, 13'h1FFF, 11'h401};
      tab[6] = '{13'h0010, 13'h0001, 11'h000};
      tab[7] = '{13'h0020, 13'h0000, 11'h000};
      pat = 66'h2_DEAD_BEEF_1234_5678;

      pReset            = 1'b1;
      bus.config_enable = 1'b0;
      bus.ccff_head     = 1'b0;
      bus.cfg_commit    = 1'b0;
      model_sr          = '0;

      // Reset with tracks toggling
      for (int i = 0; i < 3; i++) begin
         set_tracks(13'($urandom), 13'($urandom));
         #1;
         check("rst_top_out", 32'(bus.chany_top_out), 32'(bus.chany_bottom_in));
         check("rst_bottom_out", 32'(bus.chany_bottom_out), 32'(bus.chany_top_in));
         check("rst_ipin", 32'(bus.ipin_out), 32'h0);
      end
      check("rst_loaded", 32'(bus.cfg_loaded), 32'h0);
      check("rst_error", 32'(bus.cfg_error), 32'h0);
      check("rst_tail", 32'(bus.ccff_tail), 32'h0);
      @(posedge prog_clk);
      #1;
      pReset = 1'b0;

      // Full frame A
      shift_frame(CFG_A, TOTAL);
      set_tracks(13'h1FFF, 13'h1FFF);
      check("pre_commit_ipin", 32'(bus.ipin_out), 32'h0);
      check("pre_commit_loaded", 32'(bus.cfg_loaded), 32'h0);
      commit();
      check("a_loaded", 32'(bus.cfg_loaded), 32'h1);
      check("a_error", 32'(bus.cfg_error), 32'h0);
      for (int i = 0; i < 8; i++) begin
         set_tracks(tab[i].bot, tab[i].top);
         check("tab_ipin", 32'(bus.ipin_out), 32'(tab[i].exp));
         check("tab_top_out", 32'(bus.chany_top_out), 32'(tab[i].bot));
         check("tab_bottom_out", 32'(bus.chany_bottom_out), 32'(tab[i].top));
      end

      // Short frame fails, mapping A kept; full frame B then succeeds
      shift_frame(CFG_B, TOTAL - 1);
      commit();
      check("short_error", 32'(bus.cfg_error), 32'h1);
      set_tracks(13'h0000, 13'h0030);
      check("short_keep_a", 32'(bus.ipin_out), 32'h401);
      set_tracks(13'h0002, 13'h0000);
      check("short_no_b", 32'(bus.ipin_out), 32'h000);
      shift_frame(CFG_B, TOTAL);
      commit();
      check("b_loaded", 32'(bus.cfg_loaded), 32'h1);
      check("b_error_sticky", 32'(bus.cfg_error), 32'h1);
      set_tracks(13'h0002, 13'h0030);
      check("b_ipin", 32'(bus.ipin_out), 32'h002);

      // Overshift by one bit: commit fails
      shift_bit(1'b1);
      shift_frame(CFG_C, TOTAL);
      commit();
      set_tracks(13'h1FFF, 13'h1FFF);
      check("overshift_keep_b", 32'(bus.ipin_out), 32'h002);

      // Commit collides with the 33rd shift: commit sees 32 bits, bit dropped
      for (int i = TOTAL - 1; i >= 1; i--) shift_bit(CFG_C[i]);
      bus.config_enable = 1'b1;
      bus.ccff_head     = CFG_C[0];
      commit();
      bus.config_enable = 1'b0;
      check("collision_keep_b", 32'(bus.ipin_out), 32'h002);
      check("collision_error", 32'(bus.cfg_error), 32'h1);

      // Chain loop-through; tail follows the bench chain model, ipin holds B
      for (int i = 0; i < 66; i++) begin
         logic [CHAN_W-1:0] rb;
         logic [CHAN_W-1:0] rt;
         shift_bit(pat[65-i]);
         check("loop_tail", 32'(bus.ccff_tail), 32'(model_sr[TOTAL-1]));
         rb = 13'($urandom);
         rt = 13'($urandom);
         set_tracks(rb, rt);
         check("loop_ipin", 32'(bus.ipin_out), 32'(ref_ipin(CFG_B, rb, rt)));
      end
      check("loop_tail_final", 32'(bus.ccff_tail), 32'(pat[32]));

      // Saturated count: commit fails; then frame C loads
      commit();
      set_tracks(13'h1FFF, 13'h1FFF);
      check("sat_keep_b", 32'(bus.ipin_out), 32'h002);
      shift_frame(CFG_C, TOTAL);
      commit();
      check("c_ipin_ones", 32'(bus.ipin_out), 32'h004);
      set_tracks(13'h0000, 13'h0004);
      check("c_ipin_top2", 32'(bus.ipin_out), 32'h004);
      set_tracks(13'h0000, 13'h0000);
      check("c_ipin_zero", 32'(bus.ipin_out), 32'h000);

      // Mid-shift reset discards partial frame and clears everything
      for (int i = 0; i < 10; i++) shift_bit(1'b1);
      #2;
      pReset = 1'b1;
      set_tracks(13'h1FFF, 13'h1555);
      check("mid_rst_ipin", 32'(bus.ipin_out), 32'h0);
      check("mid_rst_loaded", 32'(bus.cfg_loaded), 32'h0);
      check("mid_rst_error", 32'(bus.cfg_error), 32'h0);
      check("mid_rst_tail", 32'(bus.ccff_tail), 32'h0);
      check("mid_rst_top_out", 32'(bus.chany_top_out), 32'h1FFF);
      @(posedge prog_clk);
      #1;
      pReset   = 1'b0;
      model_sr = '0;

      // Fresh frame after reset, then back-to-back commit with zero bits
      shift_frame(CFG_A, TOTAL);
      commit();
      check("post_rst_loaded", 32'(bus.cfg_loaded), 32'h1);
      check("post_rst_error", 32'(bus.cfg_error), 32'h0);
      set_tracks(13'h0000, 13'h0030);
      check("post_rst_ipin", 32'(bus.ipin_out), 32'h401);
      commit();
      check("b2b_error", 32'(bus.cfg_error), 32'h1);
      check("b2b_loaded", 32'(bus.cfg_loaded), 32'h1);
      check("b2b_ipin", 32'(bus.ipin_out), 32'h401);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
